// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing: pixel coordinates, active-low syncs, active flag, line/frame strobes.
// Define VGA_CLK_DIV_EN to advance the raster on every other clk (e.g. 50 MHz clk, 25 MHz pixels).
//
// state   | meaning
// HS_ACT  | visible columns
// HS_FP   | horizontal front porch
// HS_SYNC | hsync pulse (hsync low)
// HS_BP   | horizontal back porch
// VS_ACT  | visible rows
// VS_FP   | vertical front porch
// VS_SYNC | vsync pulse (vsync low)
// VS_BP   | vertical back porch
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] colPos,
    output logic [9:0] rowPos,
    output logic       hsync,
    output logic       vsync,
    output logic       active,
    output logic       pix_en,
    output logic       line_start,
    output logic       frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

    if (H_ACTIVE < 1 || H_FRONT < 1 || H_SYNC < 1 || H_BACK < 1 ||
        V_ACTIVE < 1 || V_FRONT < 1 || V_SYNC < 1 || V_BACK < 1 ||
        H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_param_check
        $error("vga_timing_gen: every timing parameter must be >=1 and totals <=1024");
    end

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_FP_START   = 10'(H_ACTIVE);
    localparam logic [9:0] H_SYNC_START = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0] H_BP_START   = 10'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_FP_START   = 10'(V_ACTIVE);
    localparam logic [9:0] V_SYNC_START = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] V_BP_START   = 10'(V_ACTIVE + V_FRONT + V_SYNC);

    typedef enum logic [1:0] {HS_ACT, HS_FP, HS_SYNC, HS_BP} h_state_t;
    typedef enum logic [1:0] {VS_ACT, VS_FP, VS_SYNC, VS_BP} v_state_t;

    h_state_t   h_state, h_next;
    v_state_t   v_state, v_next;
    logic [9:0] col_next, row_next;
    logic       h_wrap, v_wrap;

`ifdef VGA_CLK_DIV_EN
    logic pix_tog;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pix_tog <= 1'b0;
        else        pix_tog <= ~pix_tog;
    end

    assign pix_en = pix_tog;
`else
    assign pix_en = 1'b1;
`endif

    always_comb begin
        col_next = colPos;
        row_next = rowPos;
        h_next   = h_state;
        v_next   = v_state;
        h_wrap   = (colPos == H_LAST);
        v_wrap   = (rowPos == V_LAST);
        if (pix_en) begin
            if (h_wrap) begin
                col_next = '0;
                row_next = v_wrap ? '0 : rowPos + 10'd1;
            end else begin
                col_next = colPos + 10'd1;
            end

            // Transitions look at the next coordinate so the states line up with colPos/rowPos.
            case (h_state)
                HS_ACT:  if (col_next == H_FP_START)   h_next = HS_FP;
                HS_FP:   if (col_next == H_SYNC_START) h_next = HS_SYNC;
                HS_SYNC: if (col_next == H_BP_START)   h_next = HS_BP;
                HS_BP:   if (h_wrap)                   h_next = HS_ACT;
                default:                               h_next = HS_ACT;
            endcase

            if (h_wrap) begin
                case (v_state)
                    VS_ACT:  if (row_next == V_FP_START)   v_next = VS_FP;
                    VS_FP:   if (row_next == V_SYNC_START) v_next = VS_SYNC;
                    VS_SYNC: if (row_next == V_BP_START)   v_next = VS_BP;
                    VS_BP:   if (v_wrap)                   v_next = VS_ACT;
                    default:                               v_next = VS_ACT;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            colPos  <= '0;
            rowPos  <= '0;
            h_state <= HS_ACT;
            v_state <= VS_ACT;
            hsync   <= 1'b1;
            vsync   <= 1'b1;
            active  <= 1'b1;
        end else begin
            colPos  <= col_next;
            rowPos  <= row_next;
            h_state <= h_next;
            v_state <= v_next;
            hsync   <= (h_next != HS_SYNC);
            vsync   <= (v_next != VS_SYNC);
            active  <= (h_next == HS_ACT) && (v_next == VS_ACT);
        end
    end

    assign line_start  = pix_en && (colPos == 10'd0);
    assign frame_start = line_start && (rowPos == 10'd0);

endmodule
